cs_microsequencer: RTL and testbench
====================================

Name: cs_microsequencer

Overview:
- Next-address sequencer for the microprogrammed control unit: owns the microaddress register (uPC) and drives the control-store address incrementer (CSAI) through its jump-address and acknowledge inputs.
- Consumes the CSAI incremented output as the sequential next address and as the call return address.
- Resolves the next-address op of each microword: next, jump, conditional branch, call, return, wait, dispatch.
- Has a return stack and sticky fault flags.

Parameters:
- CSAI_LENGTH_ADDR, 11, microaddress width.
- STACK_DEPTH, 4, return-stack entries.
- COND_WIDTH, 8, number of condition inputs; COND_SEL width is clog2(COND_WIDTH).
- WAIT_TIMEOUT, 16, consecutive false-condition cycles allowed in WAIT before a trap.
- RESET_VECTOR, 11'h000, first microaddress after reset.
- TRAP_ADDR, 11'h7F0, fault handler microaddress.

Ports:
- CS_MSEQ_CLOCK_50  in  1  single clock; all state changes on rising edge.
- CS_MSEQ_RESET  in  1  synchronous, active-low reset.
- CS_MSEQ_OP  in  3  next-address op of current microword.
- CS_MSEQ_FIELD_ADDR  in  CSAI_LENGTH_ADDR  branch/jump/call target from microword.
- CS_MSEQ_COND_SEL  in  clog2(COND_WIDTH)  condition select.
- CS_MSEQ_CONDITIONS  in  COND_WIDTH  status flags from datapath.
- CS_MSEQ_DISPATCH_ADDR  in  CSAI_LENGTH_ADDR  opcode-map target.
- CS_MSEQ_CSAI_ADDR  in  CSAI_LENGTH_ADDR  CSAI output (uPC+1).
- CS_MSEQ_STALL  in  1  freeze request.
- CS_MSEQ_data_OutBUS  out  CSAI_LENGTH_ADDR  registered uPC, drives control-store address.
- CS_MSEQ_JUMP_ADDR  out  CSAI_LENGTH_ADDR  combinational next address, to CSAI jump input.
- CS_MSEQ_ACK  out  1  combinational, to CSAI acknowledge; high when uPC advances this edge.
- CS_MSEQ_SP  out  clog2(STACK_DEPTH+1)  stack pointer (number of valid entries).
- CS_MSEQ_ERROR  out  3  sticky faults: [0] overflow, [1] underflow, [2] wait timeout.

Behaviour:
- Reset (RESET low at edge):
  - State INIT, uPC=RESET_VECTOR, SP=0, ERROR=0, wait counter=0.
  - ACK forced 0 while RESET is low.
- Priority per edge: reset > stall > op.
- Lockstep with CSAI: whenever ACK=1, uPC<=JUMP_ADDR at the same edge CSAI loads JUMP_ADDR+1. Invariant: CSAI_ADDR==uPC+1 in every RUN/WAIT cycle.
- INIT (one cycle, not stallable): ACK=1, JUMP_ADDR=RESET_VECTOR, then -> RUN. This primes CSAI.
- STALL=1 in RUN/WAIT: ACK=0; uPC, SP, stack, counter and state are all frozen.
- RUN, op decode (ACK=1 unless stated):
  - 000 NEXT: JUMP_ADDR=CSAI_ADDR.
  - 001 JUMP: FIELD_ADDR.
  - 010 BRT: FIELD_ADDR if CONDITIONS[COND_SEL]=1, else CSAI_ADDR.
  - 011 BRF: FIELD_ADDR if CONDITIONS[COND_SEL]=0, else CSAI_ADDR.
  - 100 CALL: push CSAI_ADDR, SP+1, JUMP_ADDR=FIELD_ADDR. If SP==STACK_DEPTH: no push, JUMP_ADDR=TRAP_ADDR, ERROR[0]<=1.
  - 101 RET: JUMP_ADDR=top entry, SP-1. If SP==0: JUMP_ADDR=TRAP_ADDR, ERROR[1]<=1.
  - 110 WAIT: if condition true, JUMP_ADDR=CSAI_ADDR. Else ACK=0, counter<=1, -> WAIT. If WAIT_TIMEOUT==1, trap immediately instead.
  - 111 DISPATCH: DISPATCH_ADDR.
- WAIT state (op inputs still from the same microword):
  - Condition true: JUMP_ADDR=CSAI_ADDR, ACK=1, counter<=0, -> RUN.
  - Condition false with counter==WAIT_TIMEOUT-1: JUMP_ADDR=TRAP_ADDR, ACK=1, ERROR[2]<=1, counter<=0, -> RUN.
  - Otherwise: ACK=0, counter+1.
- Arithmetic and flags:
  - All addresses wrap modulo 2^CSAI_LENGTH_ADDR; NEXT at 11'h7FF yields 11'h000 via CSAI.
  - Stack entries are not cleared on pop. Contents beyond SP are don't-care.
  - ERROR bits clear only on reset. A trap does not halt sequencing.
- Reset mid-WAIT or mid-stack use: everything returns to reset values; the next non-reset cycle is INIT.

Test Plan:
- Reset low 3 cycles then release -> first edge after release: ACK=1, JUMP_ADDR=000. Next cycle: uPC=000, CSAI_ADDR=001. Issue NEXT x3 -> uPC 001, 002, 003.
- At uPC=010: CALL FIELD=100 -> uPC=100, SP=1. Then RET -> uPC=011, SP=0. Then RET again -> uPC=7F0, ERROR=3'b010.
- Five CALLs with STACK_DEPTH=4 -> SP stays 4, fifth jumps to 7F0, ERROR[0]=1. Four RETs then return to pushed addresses in LIFO order.
- WAIT with cond false 15 cycles then true -> ACK=0 for 15 cycles, uPC held, then uPC=held+1. Cond never true -> trap to 7F0 on the 16th cycle, ERROR[2]=1.
- BRT/BRF with COND_SEL=5, CONDITIONS=8'h20 -> BRT taken to FIELD, BRF falls through to uPC+1. STALL=1 for 4 cycles mid-sequence -> ACK=0 and uPC/SP unchanged throughout.
- uPC=7FF with NEXT -> uPC=000. DISPATCH with DISPATCH_ADDR=2A5 -> uPC=2A5. Reset asserted during WAIT -> SP=0, ERROR=0, INIT, uPC=000.

Source files
------------

// File: rtl/cs_microsequencer.sv
// rtl/cs_microsequencer.sv - microaddress sequencer driving the CSAI jump/ack inputs
// Owns uPC, the return stack, the WAIT timeout counter and sticky fault flags.
module cs_microsequencer #(
  parameter int CSAI_LENGTH_ADDR = 11,
  parameter int STACK_DEPTH      = 4,
  parameter int COND_WIDTH       = 8,
  parameter int WAIT_TIMEOUT     = 16,
  parameter logic [CSAI_LENGTH_ADDR-1:0] RESET_VECTOR = 11'h000,
  parameter logic [CSAI_LENGTH_ADDR-1:0] TRAP_ADDR    = 11'h7F0,
  localparam int SEL_W = $clog2(COND_WIDTH),
  localparam int SP_W  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                        CS_MSEQ_CLOCK_50,
  input  logic                        CS_MSEQ_RESET,
  input  logic [2:0]                  CS_MSEQ_OP,
  input  logic [CSAI_LENGTH_ADDR-1:0] CS_MSEQ_FIELD_ADDR,
  input  logic [SEL_W-1:0]            CS_MSEQ_COND_SEL,
  input  logic [COND_WIDTH-1:0]       CS_MSEQ_CONDITIONS,
  input  logic [CSAI_LENGTH_ADDR-1:0] CS_MSEQ_DISPATCH_ADDR,
  input  logic [CSAI_LENGTH_ADDR-1:0] CS_MSEQ_CSAI_ADDR,
  input  logic                        CS_MSEQ_STALL,
  output logic [CSAI_LENGTH_ADDR-1:0] CS_MSEQ_data_OutBUS,
  output logic [CSAI_LENGTH_ADDR-1:0] CS_MSEQ_JUMP_ADDR,
  output logic                        CS_MSEQ_ACK,
  output logic [SP_W-1:0]             CS_MSEQ_SP,
  output logic [2:0]                  CS_MSEQ_ERROR
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BRT  = 3'd2;
  localparam logic [2:0] OP_BRF  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_WAIT = 3'd6;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_WAIT} state_t;

  state_t                      state, state_n;
  logic [CSAI_LENGTH_ADDR-1:0] upc, jump;
  logic [CSAI_LENGTH_ADDR-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]             sp, sp_dec;
  logic [IDX_W-1:0]            push_idx, top_idx;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [2:0]                  err, err_set;
  logic                        ack, push, pop, cond, full, empty, wait_expired;

  assign cond         = CS_MSEQ_CONDITIONS[CS_MSEQ_COND_SEL];
  assign sp_dec       = sp - SP_W'(1);
  assign push_idx     = sp[IDX_W-1:0];
  assign top_idx      = sp_dec[IDX_W-1:0];
  assign full         = (sp == SP_W'(STACK_DEPTH));
  assign empty        = (sp == '0);
  assign wait_expired = (cnt == CNT_W'(WAIT_TIMEOUT - 1));

  // jump defaults to the CSAI output so that a plain advance keeps CSAI == uPC+1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    jump    = CS_MSEQ_CSAI_ADDR;
    ack     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 3'b000;
    case (state)
      S_INIT: begin
        ack     = 1'b1;
        jump    = RESET_VECTOR;
        cnt_n   = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        if (!CS_MSEQ_STALL) begin
          ack = 1'b1;
          case (CS_MSEQ_OP)
            OP_NEXT: jump = CS_MSEQ_CSAI_ADDR;
            OP_JUMP: jump = CS_MSEQ_FIELD_ADDR;
            OP_BRT:  if (cond)  jump = CS_MSEQ_FIELD_ADDR;
            OP_BRF:  if (!cond) jump = CS_MSEQ_FIELD_ADDR;
            OP_CALL: begin
              if (full) begin
                jump       = TRAP_ADDR;
                err_set[0] = 1'b1;
              end else begin
                jump = CS_MSEQ_FIELD_ADDR;
                push = 1'b1;
              end
            end
            OP_RET: begin
              if (empty) begin
                jump       = TRAP_ADDR;
                err_set[1] = 1'b1;
              end else begin
                jump = stack_mem[top_idx];
                pop  = 1'b1;
              end
            end
            OP_WAIT: begin
              if (!cond) begin
                if (WAIT_TIMEOUT <= 1) begin
                  jump       = TRAP_ADDR;
                  err_set[2] = 1'b1;
                end else begin
                  ack     = 1'b0;
                  cnt_n   = CNT_W'(1);
                  state_n = S_WAIT;
                end
              end
            end
            default: jump = CS_MSEQ_DISPATCH_ADDR;
          endcase
        end
      end
      S_WAIT: begin
        if (!CS_MSEQ_STALL) begin
          if (cond) begin
            ack     = 1'b1;
            cnt_n   = '0;
            state_n = S_RUN;
          end else if (wait_expired) begin
            ack        = 1'b1;
            jump       = TRAP_ADDR;
            err_set[2] = 1'b1;
            cnt_n      = '0;
            state_n    = S_RUN;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = S_INIT;
    endcase
    if (!CS_MSEQ_RESET) ack = 1'b0;
  end

  always_ff @(posedge CS_MSEQ_CLOCK_50) begin
    if (!CS_MSEQ_RESET) state <= S_INIT;
    else                state <= state_n;
  end

  always_ff @(posedge CS_MSEQ_CLOCK_50) begin
    if (!CS_MSEQ_RESET) begin
      upc <= RESET_VECTOR;
      sp  <= '0;
      cnt <= '0;
      err <= 3'b000;
    end else begin
      cnt <= cnt_n;
      err <= err | err_set;
      if (ack)       upc <= jump;
      if (push)      sp  <= sp + SP_W'(1);
      else if (pop)  sp  <= sp_dec;
    end
  end

  // Popped entries are left in place; only slots below sp are meaningful.
  always_ff @(posedge CS_MSEQ_CLOCK_50) begin
    if (CS_MSEQ_RESET && push) stack_mem[push_idx] <= CS_MSEQ_CSAI_ADDR;
  end

  assign CS_MSEQ_data_OutBUS = upc;
  assign CS_MSEQ_JUMP_ADDR   = jump;
  assign CS_MSEQ_ACK         = ack;
  assign CS_MSEQ_SP          = sp;
  assign CS_MSEQ_ERROR       = err;

endmodule

// File: tb/tb_cs_microsequencer.sv
// tb/tb_cs_microsequencer.sv - bench for cs_microsequencer with an attached CSAI model
module tb_cs_microsequencer;
  localparam int AW = 11;
  localparam int SD = 4;
  localparam int WT = 16;
  localparam int RV = 'h000;
  localparam int TRAP = 'h7F0;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] field = '0, disp = '0;
  logic [2:0]    sel = '0;
  logic [7:0]    conds = '0;
  logic          stall = 1'b0;
  logic [AW-1:0] csai = '0;
  logic [AW-1:0] upc, jump;
  logic          ack;
  logic [2:0]    sp;
  logic [2:0]    err;

  cs_microsequencer #(
    .CSAI_LENGTH_ADDR(AW), .STACK_DEPTH(SD), .COND_WIDTH(8), .WAIT_TIMEOUT(WT),
    .RESET_VECTOR(11'h000), .TRAP_ADDR(11'h7F0)
  ) dut (
    .CS_MSEQ_CLOCK_50(clk), .CS_MSEQ_RESET(rstn), .CS_MSEQ_OP(op),
    .CS_MSEQ_FIELD_ADDR(field), .CS_MSEQ_COND_SEL(sel), .CS_MSEQ_CONDITIONS(conds),
    .CS_MSEQ_DISPATCH_ADDR(disp), .CS_MSEQ_CSAI_ADDR(csai), .CS_MSEQ_STALL(stall),
    .CS_MSEQ_data_OutBUS(upc), .CS_MSEQ_JUMP_ADDR(jump), .CS_MSEQ_ACK(ack),
    .CS_MSEQ_SP(sp), .CS_MSEQ_ERROR(err)
  );

  always #5 clk = ~clk;

  // The control-store address incrementer: loads jump+1 whenever acknowledged.
  always @(posedge clk) if (ack) csai <= jump + 11'd1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply(input logic [2:0] o, input logic [AW-1:0] f, input logic [2:0] s,
                       input logic [7:0] c, input logic [AW-1:0] d, input logic st);
    op = o; field = f; sel = s; conds = c; disp = d; stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op; int field; logic [2:0] sel; logic [7:0] conds; int disp; logic stall;
    logic ack; int upc; int sp; int err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] o, input int f, input logic [2:0] s, input logic [7:0] c,
                     input int d, input logic st, input logic a, input int u, input int p, input int e);
    vec_t v;
    v.op = o; v.field = f; v.sel = s; v.conds = c; v.disp = d; v.stall = st;
    v.ack = a; v.upc = u; v.sp = p; v.err = e;
    tbl.push_back(v);
  endtask

  // Reference model: a wrap-around uPC, a queue for the return stack and a
  // count of consecutive false WAIT cycles.
  int m_upc;
  int m_stack[$];
  int m_err;
  int m_wait;
  bit m_primed;

  task automatic model_reset();
    m_upc = RV; m_stack.delete(); m_err = 0; m_wait = 0; m_primed = 0;
  endtask

  task automatic model_step(input bit rst_low, input logic [2:0] o, input int f, input logic [2:0] s,
                            input logic [7:0] c, input int d, input bit st,
                            output bit e_ack, output int e_jump);
    int nxt;
    bit cv;
    nxt = (m_upc + 1) % 2048;
    cv = c[s];
    e_ack = 1;
    e_jump = nxt;
    if (rst_low) begin
      e_ack = 0;
      model_reset();
      return;
    end
    if (!m_primed) begin
      e_jump = RV;
      m_primed = 1;
    end else if (st) begin
      e_ack = 0;
    end else begin
      case (o)
        3'd0: e_jump = nxt;
        3'd1: e_jump = f;
        3'd2: e_jump = cv ? f : nxt;
        3'd3: e_jump = cv ? nxt : f;
        3'd4: if (m_stack.size() == SD) begin e_jump = TRAP; m_err |= 1; end
              else begin m_stack.push_back(nxt); e_jump = f; end
        3'd5: if (m_stack.size() == 0) begin e_jump = TRAP; m_err |= 2; end
              else e_jump = m_stack.pop_back();
        3'd6: if (cv) m_wait = 0;
              else if (m_wait + 1 >= WT) begin e_jump = TRAP; m_err |= 4; m_wait = 0; end
              else begin e_ack = 0; m_wait++; end
        default: e_jump = d;
      endcase
    end
    if (e_ack) m_upc = e_jump;
  endtask

  bit e_ack;
  int e_jump;
  logic [2:0] r_op = '0;
  logic [AW-1:0] r_field = '0, r_disp = '0;
  logic [2:0] r_sel = '0;
  logic [7:0] r_conds = '0;
  bit r_rst, r_stall;

  initial begin
    // reset held three cycles
    apply(3'd0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("ack_in_reset", ack, 0);
      tick();
    end
    chk("reset_upc", upc, 0);
    chk("reset_sp", sp, 0);
    chk("reset_err", err, 0);
    rstn = 1'b1;
    #2 chk("init_ack", ack, 1);
    chk("init_jump", jump, RV);
    tick();
    chk("init_upc", upc, RV);
    chk("init_csai", csai, 1);

    add(0, 0, 0, 0, 0, 0, 1, 'h001, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 'h002, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 'h003, 0, 0);
    add(1, 'h010, 0, 0, 0, 0, 1, 'h010, 0, 0);
    add(4, 'h100, 0, 0, 0, 0, 1, 'h100, 1, 0);
    add(5, 0, 0, 0, 0, 0, 1, 'h011, 0, 0);
    add(5, 0, 0, 0, 0, 0, 1, 'h7F0, 0, 2);
    add(1, 'h200, 0, 0, 0, 0, 1, 'h200, 0, 2);
    add(4, 'h300, 0, 0, 0, 0, 1, 'h300, 1, 2);
    add(4, 'h310, 0, 0, 0, 0, 1, 'h310, 2, 2);
    add(4, 'h320, 0, 0, 0, 0, 1, 'h320, 3, 2);
    add(4, 'h330, 0, 0, 0, 0, 1, 'h330, 4, 2);
    add(4, 'h340, 0, 0, 0, 0, 1, 'h7F0, 4, 3);
    add(5, 0, 0, 0, 0, 0, 1, 'h321, 3, 3);
    add(5, 0, 0, 0, 0, 0, 1, 'h311, 2, 3);
    add(5, 0, 0, 0, 0, 0, 1, 'h301, 1, 3);
    add(5, 0, 0, 0, 0, 0, 1, 'h201, 0, 3);
    add(2, 'h050, 5, 8'h20, 0, 0, 1, 'h050, 0, 3);
    add(3, 'h060, 5, 8'h20, 0, 0, 1, 'h051, 0, 3);
    for (int i = 0; i < 4; i++) add(1, 'h123, 0, 0, 0, 1, 0, 'h051, 0, 3);
    add(3, 'h060, 5, 8'h00, 0, 0, 1, 'h060, 0, 3);
    add(2, 'h070, 5, 8'hDF, 0, 0, 1, 'h061, 0, 3);
    add(1, 'h7FF, 0, 0, 0, 0, 1, 'h7FF, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1, 'h000, 0, 3);
    add(7, 0, 0, 0, 'h2A5, 0, 1, 'h2A5, 0, 3);
    add(6, 0, 0, 8'h01, 0, 0, 1, 'h2A6, 0, 3);

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].field, tbl[i].sel, tbl[i].conds, tbl[i].disp, tbl[i].stall);
      #2 chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
      tick();
      chk($sformatf("vec%0d_upc", i), upc, tbl[i].upc);
      chk($sformatf("vec%0d_sp", i), sp, tbl[i].sp);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
    end

    // WAIT: 15 false cycles, then true
    apply(3'd6, 0, 3, 8'h00, 0, 0);
    for (int i = 0; i < 15; i++) begin
      #2 chk("wait_hold_ack", ack, 0);
      tick();
      chk("wait_hold_upc", upc, 'h2A6);
    end
    conds = 8'h08;
    #2 chk("wait_release_ack", ack, 1);
    chk("wait_release_jump", jump, 'h2A7);
    tick();
    chk("wait_release_upc", upc, 'h2A7);

    // WAIT never satisfied: trap on the 16th cycle
    apply(3'd6, 0, 3, 8'h00, 0, 0);
    for (int i = 0; i < 15; i++) begin
      #2 chk("wait_to_ack", ack, 0);
      tick();
    end
    #2 chk("timeout_ack", ack, 1);
    chk("timeout_jump", jump, TRAP);
    tick();
    chk("timeout_upc", upc, TRAP);
    chk("timeout_err", err, 7);

    // reset in the middle of WAIT with a stack entry live
    apply(3'd4, 'h400, 0, 0, 0, 0);
    tick();
    chk("pre_rst_sp", sp, 1);
    apply(3'd6, 0, 1, 8'h00, 0, 0);
    repeat (3) tick();
    rstn = 1'b0;
    #2 chk("midwait_rst_ack", ack, 0);
    tick();
    chk("midwait_rst_upc", upc, 0);
    chk("midwait_rst_sp", sp, 0);
    chk("midwait_rst_err", err, 0);
    rstn = 1'b1;
    #2 chk("reinit_ack", ack, 1);
    chk("reinit_jump", jump, RV);
    tick();
    apply(3'd0, 0, 0, 0, 0, 0);
    tick();
    chk("reinit_next_upc", upc, 1);

    // randomized run against the reference model
    rstn = 1'b0;
    tick();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      if (m_wait == 0) begin
        r_op = 3'($urandom_range(0, 7));
        r_field = 11'($urandom);
        r_sel = 3'($urandom);
        r_disp = 11'($urandom);
      end
      if ($urandom_range(0, 9) == 0) r_conds = 8'($urandom);
      r_stall = ($urandom_range(0, 11) == 0);
      rstn = !r_rst;
      apply(r_op, r_field, r_sel, r_conds, r_disp, r_stall);
      #2;
      chk("rnd_upc", upc, m_upc);
      chk("rnd_sp", sp, m_stack.size());
      chk("rnd_err", err, m_err);
      model_step(r_rst, r_op, r_field, r_sel, r_conds, r_disp, r_stall, e_ack, e_jump);
      chk("rnd_ack", ack, e_ack);
      if (e_ack) chk("rnd_jump", jump, e_jump);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
